// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter: an input capture register followed by one register per shift level.
// Supports SLL/SRL/SRA/ROR with bubble-collapsing valid/ready flow control; a caller tag rides along.
module shift_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 5,
  parameter int LEVELS = $clog2(WIDTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  operand,
  input  logic [LEVELS-1:0] shift_amt,
  input  logic [1:0]        shift_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int STAGES = LEVELS + 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] ready;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  // Control fields are only needed by the stage that follows, so the final stage omits them.
  logic [LEVELS-1:0] amt_q  [LEVELS];
  logic [1:0]        op_q   [LEVELS];
  logic              sign_q [LEVELS];

  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] v,
    input logic [1:0]       op,
    input logic             sign,
    input int               k
  );
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] r;
    fill_mask = ~({WIDTH{1'b1}} >> k);
    r = v;
    case (op)
      OP_SLL:  r = v << k;
      OP_SRL:  r = v >> k;
      OP_SRA:  r = (v >> k) | (sign ? fill_mask : '0);
      OP_ROR:  r = (v >> k) | (v << (WIDTH - k));
      default: r = v;
    endcase
    return r;
  endfunction

  // A stage can take new data if it, or anything downstream of it, has a free slot.
  for (genvar g = 0; g < STAGES; g++) begin : g_ready
    assign ready[g] = out_ready | ~(&valid_q[STAGES-1:g]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
        tag_q[s]  <= '0;
      end
      for (int s = 0; s < LEVELS; s++) begin
        amt_q[s]  <= '0;
        op_q[s]   <= '0;
        sign_q[s] <= 1'b0;
      end
    end else begin
      if (ready[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= operand;
          tag_q[0]  <= in_tag;
          amt_q[0]  <= shift_amt;
          op_q[0]   <= shift_op;
          sign_q[0] <= operand[WIDTH-1];
        end
      end
      // Stage s shifts by 2^(LEVELS-s): largest distance first.
      for (int s = 1; s < STAGES; s++) begin
        if (ready[s]) begin
          valid_q[s] <= valid_q[s-1];
          if (valid_q[s-1]) begin
            data_q[s] <= amt_q[s-1][LEVELS-s]
                         ? shift_level(data_q[s-1], op_q[s-1], sign_q[s-1], 1 << (LEVELS - s))
                         : data_q[s-1];
            tag_q[s]  <= tag_q[s-1];
          end
        end
      end
      for (int s = 1; s < LEVELS; s++) begin
        if (ready[s] && valid_q[s-1]) begin
          amt_q[s]  <= amt_q[s-1];
          op_q[s]   <= op_q[s-1];
          sign_q[s] <= sign_q[s-1];
        end
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[STAGES-1];
  assign result    = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe: directed vector table, random streams against a queue-based
// reference model, stall/backpressure sequences and mid-flight reset.
module tb_shift_unit_pipe;
  localparam int WIDTH  = 32;
  localparam int TAG_W  = 5;
  localparam int LEVELS = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  operand = '0;
  logic [LEVELS-1:0] shift_amt = '0;
  logic [1:0]        shift_op = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  result;
  logic [TAG_W-1:0]  out_tag;

  shift_unit_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .operand(operand), .shift_amt(shift_amt), .shift_op(shift_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]        op;
    logic [WIDTH-1:0]  val;
    logic [LEVELS-1:0] amt;
    logic [TAG_W-1:0]  tag;
    logic [WIDTH-1:0]  exp;
  } vec_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  int n_tests = 0;
  int n_fail  = 0;
  int n_accepted = 0;
  int n_drained  = 0;
  int cyc = 0;
  int first_drain = -1;
  int last_drain  = -1;
  logic last_acc = 1'b0;
  logic held_pending = 1'b0;
  logic [WIDTH-1:0] held_result = '0;
  logic [TAG_W-1:0] held_tag = '0;

  function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] v,
                                             input int amt);
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0] r;
    dbl = {v, v} >> amt;
    case (op)
      2'd0:    r = v << amt;
      2'd1:    r = v >> amt;
      2'd2:    r = WIDTH'($signed(v) >>> amt);
      default: r = dbl[WIDTH-1:0];
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_rand();
    operand   = $urandom;
    shift_amt = LEVELS'($urandom_range(0, WIDTH - 1));
    shift_op  = 2'($urandom_range(0, 3));
    in_tag    = TAG_W'($urandom);
  endtask

  // Evaluates the handshake for the coming edge, updates the scoreboard, then advances one cycle.
  task automatic tick();
    exp_t e;
    logic drn;
    #1;
    if (held_pending) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_result", result, held_result);
      check("hold_tag", {27'd0, out_tag}, {27'd0, held_tag});
    end
    last_acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain_unexpected: got result %h tag %h with nothing pending", result, out_tag);
      end else begin
        e = sb.pop_front();
        check("sb_result", result, e.res);
        check("sb_tag", {27'd0, out_tag}, {27'd0, e.tag});
      end
      n_drained++;
      if (first_drain < 0) first_drain = cyc;
      last_drain = cyc;
    end
    if (last_acc) begin
      e.res = model(shift_op, operand, int'(shift_amt));
      e.tag = in_tag;
      sb.push_back(e);
      n_accepted++;
    end
    held_pending = out_valid && !out_ready;
    held_result  = result;
    held_tag     = out_tag;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drain_all(input string name);
    int guard;
    guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && guard < 50) begin
      tick();
      guard++;
    end
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic run_one(input vec_t v);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    operand   = v.val;
    shift_amt = v.amt;
    shift_op  = v.op;
    in_tag    = v.tag;
    tick();
    check("accept", {31'd0, last_acc}, 32'd1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'd6);
    check("vec_result", result, v.exp);
    check("vec_tag", {27'd0, out_tag}, {27'd0, v.tag});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, stale;

    vecs[0]  = '{2'd2, 32'h8000_0000, 5'd4,  5'd3,  32'hF800_0000};
    vecs[1]  = '{2'd1, 32'h8000_0000, 5'd4,  5'd7,  32'h0800_0000};
    vecs[2]  = '{2'd0, 32'h0000_0001, 5'd31, 5'd9,  32'h8000_0000};
    vecs[3]  = '{2'd3, 32'h0000_0001, 5'd1,  5'd11, 32'h8000_0000};
    vecs[4]  = '{2'd3, 32'h1234_5678, 5'd8,  5'd13, 32'h7812_3456};
    vecs[5]  = '{2'd0, 32'hDEAD_BEEF, 5'd0,  5'd17, 32'hDEAD_BEEF};
    vecs[6]  = '{2'd1, 32'hDEAD_BEEF, 5'd0,  5'd19, 32'hDEAD_BEEF};
    vecs[7]  = '{2'd2, 32'hDEAD_BEEF, 5'd0,  5'd21, 32'hDEAD_BEEF};
    vecs[8]  = '{2'd3, 32'hDEAD_BEEF, 5'd0,  5'd23, 32'hDEAD_BEEF};
    vecs[9]  = '{2'd2, 32'h8000_0000, 5'd31, 5'd25, 32'hFFFF_FFFF};
    vecs[10] = '{2'd2, 32'h7FFF_FFFF, 5'd31, 5'd27, 32'h0000_0000};
    vecs[11] = '{2'd2, 32'h8F00_0001, 5'd3,  5'd31, 32'hF1E0_0000};

    // Reset state
    @(posedge clock);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_out_tag", {27'd0, out_tag}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;

    for (int i = 0; i < 12; i++) run_one(vecs[i]);

    // Back-to-back stream, no backpressure
    d0 = n_drained;
    a0 = n_accepted;
    first_drain = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_rand();
      in_valid = 1'b1;
      tick();
    end
    drain_all("stream");
    check("stream_accepts", 32'(n_accepted - a0), 32'd20);
    check("stream_results", 32'(n_drained - d0), 32'd20);
    check("stream_span", 32'(last_drain - first_drain), 32'd19);

    // Full stall: capacity is LEVELS+1 entries
    a0 = n_accepted;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_rand();
      in_valid = 1'b1;
      tick();
    end
    check("stall_accepts", 32'(n_accepted - a0), 32'd6);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    // Full pipe released with a request waiting: accept and drain in the same cycle
    out_ready = 1'b1;
    #1;
    check("full_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      set_rand();
      in_valid = 1'b1;
      tick();
    end
    drain_all("stall");

    // Random backpressure
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      set_rand();
      tick();
    end
    drain_all("random");
    check("random_balance", 32'(n_accepted), 32'(n_drained));

    // Reset with 4 ops in flight, oldest sitting at the output
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      operand   = 32'h0F0F_0F0F;
      shift_amt = LEVELS'(i * 3 + 1);
      shift_op  = 2'd3;
      in_tag    = TAG_W'(i + 1);
      in_valid  = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_tag", {27'd0, out_tag}, 32'd0);
    sb.delete();
    held_pending = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) stale++;
      tick();
    end
    check("post_rst_stale", 32'(stale), 32'd0);
    run_one(vecs[4]);
    check("final_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
